// File: rtl/shifter_pkg.sv
// Shared encodings and step-count rule for the multi-cycle register-amount shifter.
package shifter_pkg;

    localparam int SAT_LIN  = 33;
    localparam int ROR_FULL = 32;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Linear shifts saturate at 33 steps: one step past the width clears the carry too.
    function automatic logic [7:0] step_count(input sh_op_e op, input logic [7:0] amt);
        logic [7:0] n;
        if (op == SH_ROR) begin
            if (amt == 8'd0)
                n = 8'd0;
            else if (amt[4:0] == 5'd0)
                n = 8'(ROR_FULL);
            else
                n = {3'b000, amt[4:0]};
        end else begin
            n = (amt > 8'(SAT_LIN)) ? 8'(SAT_LIN) : amt;
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit-position shift step; the carry-out is the bit that falls off.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  sh_op_e            sh,
    input  logic [WIDTH-1:0]  w,
    output logic [WIDTH-1:0]  w_step,
    output logic              carry_step
);

    logic [WIDTH-1:0] left_in;
    logic [WIDTH-1:0] right_in;
    logic             fill;

    // Top bit on a right step: sign for ASR, wrap for ROR, zero for LSR.
    assign fill = (sh == SH_ASR) ? w[WIDTH-1] :
                  (sh == SH_ROR) ? w[0]       : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign left_in[gi] = 1'b0;
            end else begin : g_mid_l
                assign left_in[gi] = w[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign right_in[gi] = fill;
            end else begin : g_mid_r
                assign right_in[gi] = w[gi+1];
            end
        end
    endgenerate

    assign w_step     = (sh == SH_LSL) ? left_in : right_in;
    assign carry_step = (sh == SH_LSL) ? w[WIDTH-1] : w[0];

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter for register-specified amounts: one bit position per cycle,
// Start/Busy/Done handshake, full 0..255 amount semantics including carry-out.
module shift_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Sh,
    input  logic [7:0]       ShAmt8,
    input  logic [WIDTH-1:0] ShIn,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ShOut,
    output logic             ShCarry
);

    state_e           state_reg, state_next;
    sh_op_e           op_reg;
    logic [WIDTH-1:0] work_reg;
    logic             carry_reg;
    logic [CNTW-1:0]  count_reg;

    logic [WIDTH-1:0] work_step;
    logic             carry_step;
    logic             accept;
    logic [CNTW-1:0]  accept_count;

    assign accept       = Start && (state_reg != SHIFT);
    assign accept_count = CNTW'(step_count(sh_op_e'(Sh), ShAmt8));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .sh         (op_reg),
        .w          (work_reg),
        .w_step     (work_step),
        .carry_step (carry_step)
    );

    always_ff @(posedge CLK) begin
        if (Reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (Start)
                    state_next = (accept_count == '0) ? DONE : SHIFT;
                else
                    state_next = IDLE;
            end
            SHIFT: begin
                if (count_reg == CNTW'(1))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_reg == SHIFT);
        Done    = (state_reg == DONE);
        ShOut   = work_reg;
        ShCarry = carry_reg;
    end

    // Operands are latched at accept so later input changes cannot disturb a running shift.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            op_reg    <= SH_LSL;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else if (accept) begin
            op_reg    <= sh_op_e'(Sh);
            work_reg  <= ShIn;
            carry_reg <= CarryIn;
            count_reg <= accept_count;
        end else if (state_reg == SHIFT) begin
            work_reg  <= work_step;
            carry_reg <= carry_step;
            count_reg <= count_reg - CNTW'(1);
        end
    end

endmodule
